req_ack_responder: RTL and testbench

- Synthesizable request/acknowledge responder that consumes `req` and produces `ack`.
- Sits directly downstream of the request source, as the target of the `$rose(req) |-> ##[0:$] $rose(ack)` style checks.
- Every rising edge of `req`, as sampled on `clk`, is counted as one request.
- Each request is answered with exactly one single-cycle `ack` pulse a fixed number of cycles later.
- Up to DEPTH requests can be outstanding at once; they are served in order.

---
 rtl/req_ack_responder.sv | 102 ++++++++++
 tb/tb_req_ack_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: every rising edge of req is answered, in order,
// by one single-cycle ack pulse LATENCY cycles later, with up to DEPTH requests queued.
module req_ack_responder #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    output logic                       ack,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow
);

    // state  | meaning
    // IDLE   | nothing outstanding, waiting for a request
    // WAIT   | counting down to the next ack
    // ACK    | ack high this cycle; decide whether another request follows
    localparam int PW = $clog2(DEPTH + 1);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            req_q;
    logic            rose;
    logic            accept;
    logic            fire;
    logic [PW-1:0]   pending_inc;
    logic [PW-1:0]   pending_nxt;

    always_comb begin
        rose        = req & ~req_q;
        accept      = rose && (pending < PW'(DEPTH));
        pending_inc = pending + PW'(accept);
        // fire is true exactly when the FSM enters (or stays in) ACK at this edge
        fire        = ((state == S_WAIT) && (cnt == CW'(1))) ||
                      ((state == S_ACK) && (LATENCY == 1) && (pending_inc != '0));
        pending_nxt = pending_inc - PW'(fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            req_q    <= 1'b0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            req_q   <= req;
            ack     <= fire;
            pending <= pending_nxt;
            busy    <= (pending_nxt != '0);
            if (rose && !accept)
                overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    // Loading the full LATENCY puts the ack exactly LATENCY edges after acceptance
                    if (accept) begin
                        cnt   <= CW'(LATENCY);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    // The edge leaving ACK already counts as one cycle of the next interval
                    if (pending_inc != '0) begin
                        if (LATENCY == 1) begin
                            state <= S_ACK;
                        end else begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= S_WAIT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: directed and random req traffic checked each cycle
// against a due-time queue model of the in-order responder.
module tb_req_ack_responder;

    localparam int L  = 3;
    localparam int D  = 4;
    localparam int PW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          ack;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    always #5 clk = ~clk;

    req_ack_responder #(.LATENCY(L), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    int nassert = 0;
    int nfail   = 0;
    int k       = 0;
    int ack_cnt = 0;

    // model: one ack due time per accepted request, served in order
    int q[$];
    int mpend;
    bit movf;
    bit mprev;
    bit mfire;
    bit has_prev;
    int last_due;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        nassert++;
        assert (obs === 32'(exp)) else begin
            nfail++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpend    = 0;
        movf     = 1'b0;
        mprev    = 1'b0;
        mfire    = 1'b0;
        has_prev = 1'b0;
        last_due = 0;
    endtask

    task automatic model_edge(input bit v);
        bit rose_m;
        bit acc;
        int due;
        rose_m = v && !mprev;
        mprev  = v;
        acc    = rose_m && (mpend < D);
        if (rose_m && !acc)
            movf = 1'b1;
        if (acc) begin
            // a request arriving while the previous ack is pending or just shown
            // follows that ack by L cycles; otherwise it starts a fresh interval
            if (has_prev && (k <= last_due + 1))
                due = last_due + L;
            else
                due = k + L;
            q.push_back(due);
            last_due = due;
            has_prev = 1'b1;
            mpend++;
        end
        mfire = (q.size() > 0) && (q[0] == k);
        if (mfire) begin
            void'(q.pop_front());
            mpend--;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_ack"},      32'(ack),      int'(mfire));
        chk({tag, "_pending"},  32'(pending),  mpend);
        chk({tag, "_busy"},     32'(busy),     int'(mpend != 0));
        chk({tag, "_overflow"}, 32'(overflow), int'(movf));
    endtask

    task automatic step(input bit v, input string tag);
        req = v;
        @(posedge clk);
        k++;
        model_edge(v);
        #1;
        check_outputs(tag);
        if (ack === 1'b1)
            ack_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ack",      32'(ack),      0);
        chk("rst_pending",  32'(pending),  0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b1;
        model_reset();
        #1;
        chk("init_ack",      32'(ack),      0);
        chk("init_pending",  32'(pending),  0);
        chk("init_busy",     32'(busy),     0);
        chk("init_overflow", 32'(overflow), 0);
        #1 rst = 1'b0;

        // single request
        ack_cnt = 0;
        step(1'b1, "single");
        for (int i = 0; i < 6; i++) step(1'b0, "single");
        chk("single_ack_count", 32'(ack_cnt), 1);

        // held request, then a second rise
        ack_cnt = 0;
        for (int i = 0; i < 19; i++) step(1'b1, "held");
        step(1'b0, "held");
        for (int i = 0; i < 4; i++) step(1'b1, "held");
        for (int i = 0; i < 6; i++) step(1'b0, "held");
        chk("held_ack_count", 32'(ack_cnt), 2);

        // back-to-back queued requests
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "queue");
            step(1'b0, "queue");
        end
        for (int i = 0; i < 12; i++) step(1'b0, "queue");

        // sustained traffic until the queue overflows
        for (int i = 0; i < 14; i++) begin
            step(1'b1, "ovf");
            step(1'b0, "ovf");
        end
        for (int i = 0; i < 20; i++) step(1'b0, "ovf");

        // reset in the middle of a request
        step(1'b1, "midrst");
        step(1'b0, "midrst");
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, "midrst");
        step(1'b1, "midrst");
        for (int i = 0; i < 6; i++) step(1'b0, "midrst");

        // reset released with req high: rise seen on the first edge
        req = 1'b1;
        do_reset();
        step(1'b1, "rsthigh");
        for (int i = 0; i < 5; i++) step(1'b0, "rsthigh");

        // random traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            step(1'($urandom_range(0, 1)), "rand");
        end
        for (int i = 0; i < 20; i++) step(1'b0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
